// File: rtl/sb_pkg.sv
// sb_pkg: shared types for the posted-store buffer.
// Entry layout, FSM states and the default queue depth.
package sb_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LOAD_REQ,
    LOAD_DONE
  } sb_state_t;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// sb_fwd_merge: per-byte store-to-load forwarding.
// Walks oldest to newest so the youngest matching byte wins.
module sb_fwd_merge
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [PW:0]       count,
  input  logic [29:0]       addr,
  output logic [3:0]        hit,
  output logic [31:0]       data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = '0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((PW+1)'(i) < count && entries[idx].addr == addr) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].be[b]) begin
            hit[b]         = 1'b1;
            data[b*8 +: 8] = entries[idx].data[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-store queue with newest-wins load forwarding.
// Define STORE_BUFFER_COALESCE_EN to merge same-word stores into the tail.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [3:0]  byteEnable,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  sb_entry_t     q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  sb_state_t     state;
  logic [31:0]   ld_data;

  logic [29:0] waddr;
  logic [3:0]  hit;
  logic [31:0] fwd;
  logic        is_load;
  logic        full_hit;
  logic        merge;
  logic        push;
  logic        wmerge;
  logic        pop;
  logic        drive_st;
  logic        unused_ok;

  assign waddr     = ALUResult[31:2];
  assign unused_ok = ^ALUResult[1:0];
  assign is_load   = MemRead && !MemWrite;
  assign full_hit  = (hit & byteEnable) == byteEnable;
  assign drive_st  = (state == IDLE || state == DRAIN) && count != '0;
  assign pop       = drive_st && mem_ack;

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PW-1:0] last;
  assign last  = tail - PW'(1);
  // a single entry is the head being driven, so it never absorbs a store
  assign merge = count > (PW+1)'(1) && q[last].addr == waddr;
`else
  assign merge = 1'b0;
`endif

  assign push   = MemWrite && !Stall && !merge;
  assign wmerge = MemWrite && !Stall && merge;

  sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
    .entries (q),
    .head    (head),
    .count   (count),
    .addr    (waddr),
    .hit     (hit),
    .data    (fwd)
  );

  always_comb begin
    Stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (MemWrite)
          Stall = count == FULL && !merge;
        else if (MemRead)
          Stall = !full_hit;
      end
      DRAIN, LOAD_REQ: Stall = 1'b1;
      default: Stall = 1'b0;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (drive_st) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {q[head].addr, 2'b00};
      mem_wdata = q[head].data;
      mem_be    = q[head].be;
    end else if (state == LOAD_REQ) begin
      mem_req  = 1'b1;
      mem_addr = {waddr, 2'b00};
      mem_be   = byteEnable;
    end
  end

  always_comb begin
    ReadData = '0;
    if (state == LOAD_DONE)
      ReadData = ld_data;
    else if (state == IDLE && is_load && full_hit)
      ReadData = fwd & be_mask(byteEnable);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      state   <= IDLE;
      ld_data <= '0;
    end else begin
      if (push) begin
        q[tail] <= '{addr: waddr, data: WriteData, be: byteEnable};
        tail    <= tail + PW'(1);
      end
`ifdef STORE_BUFFER_COALESCE_EN
      if (wmerge) begin
        for (int b = 0; b < 4; b++)
          if (byteEnable[b])
            q[last].data[b*8 +: 8] <= WriteData[b*8 +: 8];
        q[last].be <= q[last].be | byteEnable;
      end
`endif
      if (pop)
        head <= head + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      unique case (state)
        IDLE:
          if (is_load && !full_hit)
            state <= DRAIN;
        DRAIN:
          if (count == '0)
            state <= LOAD_REQ;
        LOAD_REQ:
          if (mem_ack) begin
            ld_data <= mem_rdata & be_mask(byteEnable);
            state   <= LOAD_DONE;
          end
        LOAD_DONE:
          state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

  logic unused_wmerge;
  assign unused_wmerge = wmerge;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of the posted-store buffer.
// Bench-side memory logs committed writes and compares to a model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [3:0]  byteEnable = '0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata = '0;

  logic ack_man = 1'b0;
  logic ack_auto = 1'b0;
  logic auto_en = 1'b0;
  int   dly = 0;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq [$];
  logic [31:0] img [logic [31:0]];
  logic [31:0] refm [6];

  assign mem_ack = auto_en ? ack_auto : ack_man;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .byteEnable (byteEnable),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // a write commits at the next rising edge when req and ack are both high
  always @(negedge clk) begin
    if (!reset && mem_req && mem_ack && mem_we) begin
      logic [31:0] tmp;
      tmp = img.exists(mem_addr) ? img[mem_addr] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) tmp[8*b +: 8] = mem_wdata[8*b +: 8];
      img[mem_addr] = tmp;
      wq.push_back(mem_addr);
    end
  end

  always @(posedge clk) begin
    #3;
    if (ack_auto) ack_auto = 1'b0;
    else if (auto_en && mem_req) begin
      if (dly == 0) begin
        ack_auto = 1'b1;
        dly = $urandom_range(0, 3);
      end else dly--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    MemWrite = 1'b1; ALUResult = a; WriteData = d; byteEnable = b;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic wait_rd(input string tag);
    int n = 0;
    while (!(mem_req && !mem_we) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 20), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;

    // reset
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_rdata", ReadData, 32'h0);

    // full forward hit, no read request
    st(32'h100, 32'h11223344, 4'hF);
    MemRead = 1'b1; ALUResult = 32'h100; byteEnable = 4'hF;
    #1;
    chk("hit_rdata", ReadData, 32'h11223344);
    chk("hit_stall", 32'(Stall), 32'd0);
    chk("hit_we", 32'(mem_we), 32'd1);
    chk("hit_waddr", mem_addr, 32'h100);
    byteEnable = 4'b0010;
    #1;
    chk("hit_lane", ReadData, 32'h00003300);
    MemRead = 1'b0;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    #1;
    chk("a_drained", 32'(mem_req), 32'd0);

    // partial hit: drain then read
    st(32'h200, 32'h000000AA, 4'b0001);
    MemRead = 1'b1; ALUResult = 32'h200; byteEnable = 4'hF;
    #1;
    chk("part_stall", 32'(Stall), 32'd1);
    chk("part_rdata0", ReadData, 32'h0);
    tick(); tick();
    ack_man = 1'b1;
    #1;
    chk("part_waddr", mem_addr, 32'h200);
    chk("part_wdata", mem_wdata, 32'h000000AA);
    base = wq.size();
    tick();
    ack_man = 1'b0;
    wait_rd("part_rdreq");
    chk("part_wfirst", 32'(base), 32'(wq.size() - 1));
    chk("part_raddr", mem_addr, 32'h200);
    chk("part_rbe", 32'(mem_be), 32'hF);
    chk("part_rstall", 32'(Stall), 32'd1);
    mem_rdata = 32'hDEADBEAA;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("done_stall", 32'(Stall), 32'd0);
    chk("done_rdata", ReadData, 32'hDEADBEAA);
    MemRead = 1'b0;
    tick();
    chk("done_clear", ReadData, 32'h0);
    chk("done_idle", 32'(Stall), 32'd0);

    // full queue stalls the fifth store
    base = wq.size();
    for (int i = 0; i < 4; i++) begin
      MemWrite = 1'b1; ALUResult = 32'h400 + 32'(4*i);
      WriteData = 32'hC0 + 32'(i); byteEnable = 4'hF;
      #1;
      chk("fill_stall", 32'(Stall), 32'd0);
      tick();
    end
    ALUResult = 32'h410; WriteData = 32'hC4;
    #1;
    chk("full_stall", 32'(Stall), 32'd1);
    chk("full_head", mem_addr, 32'h400);
    ack_man = 1'b1;
    #1;
    chk("full_ack_stall", 32'(Stall), 32'd1);
    tick();
    ack_man = 1'b0;
    #1;
    chk("full_free", 32'(Stall), 32'd0);
    tick();
    MemWrite = 1'b0;
    ack_man = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      chk("ord_addr", mem_addr, 32'h400 + 32'(4*i));
      chk("ord_data", mem_wdata, 32'hC0 + 32'(i));
      tick();
    end
    ack_man = 1'b0;
    #1;
    chk("ord_empty", 32'(mem_req), 32'd0);
    chk("ord_cnt", 32'(wq.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("ord_log", wq[base + i], 32'h400 + 32'(4*i));

    // same-word stores behind an older head
    st(32'h2F0, 32'h1, 4'hF);
    st(32'h300, 32'h000000AA, 4'b0001);
    MemWrite = 1'b1; ALUResult = 32'h300;
    WriteData = 32'h0000BB00; byteEnable = 4'b0010;
    #1;
    chk("co_stall", 32'(Stall), 32'd0);
    tick();
    MemWrite = 1'b0;
    MemRead = 1'b1; byteEnable = 4'b0011;
    #1;
    chk("co_fwd", ReadData, 32'h0000BBAA);
    MemRead = 1'b0;
    ack_man = 1'b1;
    #1;
    chk("co_head", mem_addr, 32'h2F0);
    tick();
`ifdef STORE_BUFFER_COALESCE_EN
    chk("co_wdata", mem_wdata, 32'h0000BBAA);
    chk("co_be", 32'(mem_be), 32'h3);
    tick();
`else
    chk("nc_wdata0", mem_wdata, 32'h000000AA);
    chk("nc_be0", 32'(mem_be), 32'h1);
    tick();
    chk("nc_wdata1", mem_wdata, 32'h0000BB00);
    chk("nc_be1", 32'(mem_be), 32'h2);
    tick();
`endif
    ack_man = 1'b0;
    #1;
    chk("co_empty", 32'(mem_req), 32'd0);

    // reset mid-drain and mid-load
    st(32'h500, 32'h55, 4'hF);
    st(32'h504, 32'h56, 4'hF);
    MemRead = 1'b1; ALUResult = 32'h600; byteEnable = 4'hF;
    #1;
    chk("e_stall", 32'(Stall), 32'd1);
    tick();
    base = wq.size();
    reset = 1'b1;
    MemRead = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("e_req", 32'(mem_req), 32'd0);
    chk("e_stall0", 32'(Stall), 32'd0);
    ack_man = 1'b1;
    tick(); tick();
    ack_man = 1'b0;
    #1;
    chk("e_late", 32'(mem_req), 32'd0);
    chk("e_nowr", 32'(wq.size()), 32'(base));
    MemRead = 1'b1; ALUResult = 32'h500;
    #1;
    chk("e_gone", 32'(Stall), 32'd1);
    wait_rd("e_rdreq");
    reset = 1'b1;
    MemRead = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("l_req", 32'(mem_req), 32'd0);
    chk("l_stall", 32'(Stall), 32'd0);
    mem_rdata = 32'hBADBAD00;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    #1;
    chk("l_rdata", ReadData, 32'h0);
    chk("l_stall1", 32'(Stall), 32'd0);
    chk("l_req1", 32'(mem_req), 32'd0);

    // wrapping stores against a random-latency memory
    for (int k = 0; k < 6; k++) refm[k] = 32'h0;
    auto_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 32'h800 + 32'(4*(i % 6));
      d = $urandom;
      b = 4'($urandom_range(1, 15));
      for (int j = 0; j < 4; j++)
        if (b[j]) refm[i % 6][8*j +: 8] = d[8*j +: 8];
      MemWrite = 1'b1; ALUResult = a; WriteData = d; byteEnable = b;
      n = 0;
      #1;
      while (Stall && n < 50) begin
        tick();
        n++;
      end
      chk("r_accept", 32'(n < 50), 32'd1);
      tick();
    end
    MemWrite = 1'b0;
    n = 0;
    while (mem_req && n < 200) begin
      tick();
      n++;
    end
    chk("r_drain", 32'(n < 200), 32'd1);
    auto_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a = 32'h800 + 32'(4*k);
      d = img.exists(a) ? img[a] : 32'h0;
      chk("r_image", d, refm[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
